// File: rtl/riscv_pkg.sv
// Shared encodings for the memory/writeback stage: writeback select,
// load funct3 codes and the stage state machine.
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        DRAIN    = 2'b10
    } stage_state_e;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a loaded word and sign/zero extends it;
// flags misaligned halfword/word accesses, which pass the raw word through.
module load_extend
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] rdata,
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr_lo,
    output logic [N-1:0] data,
    output logic         misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[8*addr_lo +: 8];
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{(N-8){lane_b[7]}}, lane_b};
            F3_LBU: data = {{(N-8){1'b0}}, lane_b};
            F3_LH, F3_LHU: begin
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else if (funct3 == F3_LH) begin
                    data = {{(N-16){lane_h[15]}}, lane_h};
                end else begin
                    data = {{(N-16){1'b0}}, lane_h};
                end
            end
            F3_LW:   misalign = (addr_lo != 2'b00);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage feeding the 3:1 writeback mux: registers ALU result,
// load data and PC+4, stalls on outstanding loads and handles flush.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int N  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [N-1:0]  alu_res_i,
    input  logic [N-1:0]  pc4_i,
    input  logic [RA-1:0] rd_i,
    input  logic          reg_write_i,
    input  logic [1:0]    wb_sel_i,
    input  logic [2:0]    funct3_i,
    input  logic [N-1:0]  dmem_rdata_i,
    input  logic          dmem_rvalid_i,
    output logic [N-1:0]  a_o,
    output logic [N-1:0]  b_o,
    output logic [N-1:0]  c_o,
    output logic [1:0]    s_o,
    output logic [RA-1:0] rd_o,
    output logic          wb_valid_o,
    output logic          wb_we_o,
    output logic          misalign_o
);

    stage_state_e state_q, state_d;

    logic          accept;
    logic          alu_wb;
    logic          load_wb;

    logic [N-1:0]  p_alu;
    logic [N-1:0]  p_pc4;
    logic [RA-1:0] p_rd;
    logic          p_rw;
    logic [2:0]    p_f3;
    logic [1:0]    p_addr_lo;

    logic [N-1:0]  ext_data;
    logic          ext_mis;

    assign in_ready_o = (state_q == IDLE) & rst_n;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;

    load_extend #(.N(N)) u_ext (
        .rdata    (dmem_rdata_i),
        .funct3   (p_f3),
        .addr_lo  (p_addr_lo),
        .data     (ext_data),
        .misalign (ext_mis)
    );

    always_comb begin
        state_d = state_q;
        alu_wb  = 1'b0;
        load_wb = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wb_sel_i == WB_MEM) state_d = WAIT_MEM;
                    else                    alu_wb  = 1'b1;
                end
            end
            WAIT_MEM: begin
                // A flush coinciding with the return simply discards the data.
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    load_wb = ~flush_i;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_o        <= '0;
            b_o        <= '0;
            c_o        <= '0;
            s_o        <= '0;
            rd_o       <= '0;
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            p_alu      <= '0;
            p_pc4      <= '0;
            p_rd       <= '0;
            p_rw       <= 1'b0;
            p_f3       <= '0;
            p_addr_lo  <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_o <= alu_wb | load_wb;
            misalign_o <= load_wb & ext_mis;
            wb_we_o    <= 1'b0;
            if (accept) begin
                p_alu     <= alu_res_i;
                p_pc4     <= pc4_i;
                p_rd      <= rd_i;
                p_rw      <= reg_write_i;
                p_f3      <= funct3_i;
                p_addr_lo <= alu_res_i[1:0];
            end
            if (alu_wb) begin
                a_o     <= alu_res_i;
                c_o     <= pc4_i;
                s_o     <= (wb_sel_i == 2'b11) ? 2'b00 : wb_sel_i;
                rd_o    <= rd_i;
                wb_we_o <= reg_write_i & (|rd_i) & (wb_sel_i != 2'b11);
            end
            if (load_wb) begin
                a_o     <= p_alu;
                b_o     <= ext_data;
                c_o     <= p_pc4;
                s_o     <= WB_MEM;
                rd_o    <= p_rd;
                wb_we_o <= p_rw & (|p_rd) & ~ext_mis;
            end
        end
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/writeback pipeline stage that directly feeds the 3:1 writeback mux (mux31).
- Registers the ALU result, the load data and PC+4 for one instruction, then presents them as the mux's a/b/c inputs with select s.
- Stalls upstream while waiting for data-memory load returns and sign/zero-extends load data.
- Handles flush, including loads already in flight.

Parameters:
N, 32, datapath/XLEN width
RA, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  discard current/pending instruction
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  stage can accept
alu_res_i  in  N  ALU result / effective address
pc4_i  in  N  PC+4
rd_i  in  RA  destination register
reg_write_i  in  1  instruction writes rd
wb_sel_i  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
funct3_i  in  3  load width/sign
dmem_rdata_i  in  N  data-memory read word
dmem_rvalid_i  in  1  read data valid (>=1 cycle after accept)
a_o  out  N  ALU result to mux31 a
b_o  out  N  extended load data to mux31 b
c_o  out  N  PC+4 to mux31 c
s_o  out  2  select to mux31 s
rd_o  out  RA  destination register
wb_valid_o  out  1  one-cycle pulse: writeback this cycle
wb_we_o  out  1  register-file write enable
misalign_o  out  1  one-cycle pulse with wb_valid_o, misaligned load

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all registered outputs 0.
  - in_ready_o=0 while rst_n low; 1 in IDLE after release.
- States:
  - IDLE: ready.
  - WAIT_MEM: load issued, awaiting rvalid.
  - DRAIN: flushed load, awaiting rvalid to discard.
- in_ready_o is combinational: 1 iff state==IDLE and rst_n high. Accepting in IDLE also covers back-to-back accepts.
- Accept happens when in_valid_i & in_ready_o & !flush_i at a rising edge. At accept, capture alu_res, pc4, rd, reg_write, wb_sel, funct3 and addr_lo=alu_res_i[1:0].
- Non-load (wb_sel!=01), accepted at edge k:
  - a_o/c_o/s_o/rd_o update at edge k.
  - wb_valid_o=1 for exactly cycle k+1.
  - State stays IDLE, so back-to-back non-loads give wb_valid every cycle.
- Load (wb_sel==01), accepted at edge k:
  - Go to WAIT_MEM.
  - On the edge m where dmem_rvalid_i=1: b_o=extend(rdata); wb_valid_o=1 in cycle m+1; return to IDLE.
- Load extension:
  - funct3 000 LB / 100 LBU: byte lane addr_lo, sign/zero extended.
  - 001 LH / 101 LHU: half lane addr_lo[1], sign/zero extended.
  - 010 LW and all other codes: raw word.
- Misalignment:
  - Misaligned cases: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=00.
  - Effect: misalign_o=1 with wb_valid_o; wb_we_o=0; b_o=raw word.
- wb_sel=11: s_o=00; wb_we_o=0.
- wb_we_o = wb_valid_o & reg_write & rd!=0 & !misalign & wb_sel!=11.
- a_o/b_o/c_o/s_o/rd_o hold their values while wb_valid_o=0. b_o updates only on load return.
- Flush:
  - flush_i in IDLE: no accept; any wb_valid_o due next cycle is suppressed. A wb_valid_o already high in the flush cycle still completes.
  - flush_i in WAIT_MEM without rvalid: go to DRAIN; no writeback.
  - flush_i with rvalid in WAIT_MEM: data discarded; go to IDLE.
  - In DRAIN: in_ready_o=0; flush_i ignored; rvalid returns to IDLE with no wb_valid_o.
- dmem_rvalid_i in IDLE is a protocol violation and is ignored; outputs are unchanged.
- Async reset mid-load: state returns to IDLE; a later stray rvalid is ignored.

Decomposition:
- riscv_pkg:
  - wb_sel_e (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - stage_state_e (IDLE, WAIT_MEM, DRAIN).
- Sub-module load_extend: combinational; inputs rdata, funct3, addr_lo; outputs data and misalign.

Test Plan:
- Reset release, then ADD with alu_res=32'h0000_1234, rd=5, wb_sel=00 -> next cycle wb_valid=1, a_o=32'h1234, s_o=00, wb_we=1.
- LB with alu_res=32'h100 (lane 0), rvalid 3 cycles later with rdata=32'h1234_5680 -> in_ready=0 for 3 cycles; b_o=32'hFFFF_FF80, s_o=01; LBU gives 32'h0000_0080.
- LH with addr_lo=01 and rdata=32'hBABE_FACE -> misalign_o=1, wb_we_o=0, wb_valid_o=1.
- JAL with pc4=32'hABCD_EF12, rd=1, wb_sel=10 -> c_o=32'hABCD_EF12, s_o=10. Same instruction with rd=0 -> wb_we_o=0.
- Flush in WAIT_MEM, then rvalid 2 cycles later -> state DRAIN; no wb_valid; in_ready returns to 1 the cycle after rvalid.
- Four back-to-back non-loads (in_valid held), flush asserted on the 3rd -> wb_valid for instructions 1 and 2 only; the 4th is accepted after flush drops.
